// File: rtl/cat_deploy_ctrl.sv
// Card-deploy controller: money/purse economy, per-card cooldowns and an IDLE->EVAL->ISSUE request FSM.
// Optional fire cannon is built only when FIRE_CANNON_EN is defined.
module cat_deploy_ctrl #(
  parameter logic [13:0] MONEY_MAX   = 14'd9999,
  parameter logic [13:0] INCOME_BASE = 14'd2,
  parameter logic [7:0]  FIRE_CD     = 8'd120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        click_valid,
  input  logic [2:0]  click_slot,
  input  logic        purse_click,
  input  logic        fire_click,
  output logic [13:0] money,
  output logic [2:0]  purse_level,
  output logic [7:0]  slot_ready,
  output logic        spawn_valid,
  output logic [2:0]  spawn_type,
  output logic        reject,
  output logic        busy,
  output logic        fire_ready,
  output logic        fire_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_ISSUE
  } state_t;

  function automatic logic [13:0] card_cost(input logic [2:0] slot);
    case (slot)
      3'd0:    card_cost = 14'd50;
      3'd1:    card_cost = 14'd100;
      3'd2:    card_cost = 14'd150;
      3'd3:    card_cost = 14'd200;
      3'd4:    card_cost = 14'd300;
      3'd5:    card_cost = 14'd400;
      3'd6:    card_cost = 14'd500;
      default: card_cost = 14'd750;
    endcase
  endfunction

  function automatic logic [5:0] card_reload(input logic [2:0] slot);
    case (slot)
      3'd0:    card_reload = 6'd10;
      3'd1:    card_reload = 6'd15;
      3'd2:    card_reload = 6'd20;
      3'd3:    card_reload = 6'd25;
      3'd4:    card_reload = 6'd30;
      3'd5:    card_reload = 6'd40;
      3'd6:    card_reload = 6'd50;
      default: card_reload = 6'd60;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        req_card_q;
  logic [2:0]  req_slot_q;
  logic        grant_q, grant_d;
  logic [13:0] money_q, money_d;
  logic [2:0]  level_q, level_d;
  logic [5:0]  cd_q [8];
  logic [5:0]  cd_d [8];
  logic        spawn_valid_q, reject_q;
  logic [2:0]  spawn_type_q;

  logic [3:0]  level_inc;
  logic [13:0] purse_cost;
  logic        issue, card_grant, purse_grant;
  logic [13:0] deduct;
  logic [14:0] income, money_sum;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (click_valid || purse_click) state_d = S_EVAL;
      S_EVAL:  state_d = S_ISSUE;
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign level_inc  = {1'b0, level_q} + 4'd1;
  assign purse_cost = 14'd50 * {10'd0, level_inc};

  always_comb begin
    grant_d = 1'b0;
    if (req_card_q)
      grant_d = (cd_q[req_slot_q] == 6'd0) && (money_q >= card_cost(req_slot_q));
    else
      grant_d = (level_q != 3'd7) && (money_q >= purse_cost);
  end

  // Money can only grow between EVAL and ISSUE, so the registered grant is still affordable here.
  assign issue       = (state_q == S_ISSUE);
  assign card_grant  = issue && grant_q && req_card_q;
  assign purse_grant = issue && grant_q && !req_card_q;

  always_comb begin
    deduct = 14'd0;
    if (card_grant)  deduct = card_cost(req_slot_q);
    if (purse_grant) deduct = purse_cost;
    income    = tick ? ({1'b0, INCOME_BASE} * {11'd0, level_inc}) : 15'd0;
    money_sum = {1'b0, money_q} - {1'b0, deduct} + income;
    money_d   = (money_sum > {1'b0, MONEY_MAX}) ? MONEY_MAX : money_sum[13:0];
    level_d   = purse_grant ? (level_q + 3'd1) : level_q;
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cd_d[i] = cd_q[i];
      if (card_grant && (req_slot_q == 3'(i)))
        cd_d[i] = card_reload(3'(i));
      else if (tick && (cd_q[i] != 6'd0))
        cd_d[i] = cd_q[i] - 6'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_card_q    <= 1'b0;
      req_slot_q    <= 3'd0;
      grant_q       <= 1'b0;
      money_q       <= 14'd0;
      level_q       <= 3'd0;
      spawn_valid_q <= 1'b0;
      spawn_type_q  <= 3'd0;
      reject_q      <= 1'b0;
      // NOTE: the cooldown array is eight small flop counters, not a RAM, so it is reset like any register.
      for (int i = 0; i < 8; i++) cd_q[i] <= 6'd0;
    end else begin
      state_q <= state_d;
      money_q <= money_d;
      level_q <= level_d;
      for (int i = 0; i < 8; i++) cd_q[i] <= cd_d[i];
      if (state_q == S_IDLE) begin
        if (click_valid) begin
          req_card_q <= 1'b1;
          req_slot_q <= click_slot;
        end else if (purse_click) begin
          req_card_q <= 1'b0;
        end
      end
      if (state_q == S_EVAL) grant_q <= grant_d;
      spawn_valid_q <= card_grant;
      reject_q      <= issue && !grant_q;
      if (card_grant) spawn_type_q <= req_slot_q;
    end
  end

  always_comb begin
    slot_ready = 8'd0;
    for (int i = 0; i < 8; i++)
      slot_ready[i] = (cd_q[i] == 6'd0) && (money_q >= card_cost(3'(i)));
  end

  assign money       = money_q;
  assign purse_level = level_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_type  = spawn_type_q;
  assign reject      = reject_q;
  assign busy        = (state_q != S_IDLE);

`ifdef FIRE_CANNON_EN
  logic [7:0] fire_cd_q;
  logic       fire_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_cd_q    <= 8'd0;
      fire_valid_q <= 1'b0;
    end else if (fire_click && (fire_cd_q == 8'd0)) begin
      fire_cd_q    <= FIRE_CD;
      fire_valid_q <= 1'b1;
    end else begin
      fire_valid_q <= 1'b0;
      if (tick && (fire_cd_q != 8'd0)) fire_cd_q <= fire_cd_q - 8'd1;
    end
  end

  assign fire_ready = (fire_cd_q == 8'd0);
  assign fire_valid = fire_valid_q;
`else
  logic unused_fire_click;
  assign unused_fire_click = fire_click;
  assign fire_ready        = 1'b0;
  assign fire_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_cat_deploy_ctrl.sv
// Directed self-checking bench for cat_deploy_ctrl; define FIRE_CANNON_EN to also cover the fire cannon.
module tb_cat_deploy_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        click_valid = 1'b0;
  logic [2:0]  click_slot = 3'd0;
  logic        purse_click = 1'b0;
  logic        fire_click = 1'b0;
  logic [13:0] money;
  logic [2:0]  purse_level;
  logic [7:0]  slot_ready;
  logic        spawn_valid;
  logic [2:0]  spawn_type;
  logic        reject;
  logic        busy;
  logic        fire_ready;
  logic        fire_valid;

  int checks = 0;
  int errors = 0;

  cat_deploy_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .click_valid(click_valid), .click_slot(click_slot),
    .purse_click(purse_click), .fire_click(fire_click),
    .money(money), .purse_level(purse_level), .slot_ready(slot_ready),
    .spawn_valid(spawn_valid), .spawn_type(spawn_type), .reject(reject),
    .busy(busy), .fire_ready(fire_ready), .fire_valid(fire_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Holds tick high across n rising edges; returns on a negedge.
  task automatic ticks(input int n);
    @(negedge clk);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  // One request; optional tick coincident with the ISSUE edge. Returns just after edge N+2.
  task automatic send(input logic is_card, input logic [2:0] slot, input logic tick_issue);
    @(negedge clk);
    click_valid = is_card;
    click_slot  = slot;
    purse_click = !is_card;
    @(negedge clk);
    click_valid = 1'b0;
    purse_click = 1'b0;
    check("busy_eval", busy, 1);
    @(negedge clk);
    check("no_early_pulse", {spawn_valid, reject}, 0);
    tick = tick_issue;
    @(negedge clk);
    tick = 1'b0;
    check("busy_done", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_money", money, 0);
    check("rst_level", purse_level, 0);
    check("rst_ready", slot_ready, 0);
    check("rst_pulses", {spawn_valid, reject, fire_valid, busy}, 0);
    rst_n = 1'b1;
`ifdef FIRE_CANNON_EN
    check("rst_fire_ready", fire_ready, 1);
`else
    check("rst_fire_ready", fire_ready, 0);
`endif

    // 25 ticks at level 0, then deploy slot 0
    ticks(25);
    check("income_25", money, 50);
    check("ready_50", slot_ready, 8'h01);
    send(1'b1, 3'd0, 1'b0);
    check("s0_spawn", spawn_valid, 1);
    check("s0_type", spawn_type, 0);
    check("s0_money", money, 0);
    check("s0_ready", slot_ready[0], 0);
    @(negedge clk);
    check("s0_pulse_1cyc", spawn_valid, 0);
    ticks(10);
    check("s0_money_10t", money, 20);
    check("s0_ready_10t", slot_ready, 0);

    // Insufficient money for slot 1
    ticks(35);
    check("money_90", money, 90);
    check("ready_90", slot_ready, 8'h01);
    send(1'b1, 3'd1, 1'b0);
    check("s1_reject", reject, 1);
    check("s1_no_spawn", spawn_valid, 0);
    check("s1_money", money, 90);

    // Tick coincident with a grant: 60 - 50 + 2
    send(1'b1, 3'd0, 1'b0);
    check("s0b_money", money, 40);
    ticks(10);
    check("money_60", money, 60);
    check("ready_cd_done", slot_ready, 8'h01);
    send(1'b1, 3'd0, 1'b1);
    check("coinc_spawn", spawn_valid, 1);
    check("coinc_money", money, 12);

    // Purse upgrade
    ticks(44);
    check("money_100", money, 100);
    check("ready_100", slot_ready, 8'h03);
    send(1'b0, 3'd0, 1'b0);
    check("purse_level", purse_level, 1);
    check("purse_money", money, 50);
    check("purse_no_pulse", {spawn_valid, reject}, 0);
    ticks(1);
    check("income_lvl1", money, 54);

    // Card and purse together, plus a second click while busy
    @(negedge clk);
    click_valid = 1'b1; click_slot = 3'd0; purse_click = 1'b1;
    @(negedge clk);
    purse_click = 1'b0;
    @(negedge clk);
    click_valid = 1'b0;
    check("dual_busy", busy, 1);
    @(negedge clk);
    check("dual_spawn", spawn_valid, 1);
    check("dual_type", spawn_type, 0);
    check("dual_money", money, 4);
    check("dual_level", purse_level, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dropped_quiet", {spawn_valid, reject, busy}, 0);
    end

    // Unaffordable purse upgrade (cost 100 at level 1)
    send(1'b0, 3'd0, 1'b0);
    check("purse_reject", reject, 1);
    check("purse_rej_money", money, 4);
    check("purse_rej_level", purse_level, 1);

    // Saturation, then reload-vs-decrement on a coincident tick
    ticks(2600);
    check("sat_money", money, 9999);
    ticks(1);
    check("sat_hold", money, 9999);
    check("ready_all", slot_ready, 8'hFF);
    send(1'b1, 3'd0, 1'b1);
    check("sat_grant_money", money, 9953);
    ticks(9);
    check("cd0_after9", slot_ready[0], 0);
    ticks(1);
    check("cd0_after10", slot_ready[0], 1);
    check("money_9993", money, 9993);
    send(1'b1, 3'd7, 1'b0);
    check("s7_spawn", spawn_valid, 1);
    check("s7_type", spawn_type, 7);
    check("s7_money", money, 9243);
    check("s7_ready", slot_ready, 8'h7F);

    // Fire cannon
    @(negedge clk);
    fire_click = 1'b1;
    @(negedge clk);
    fire_click = 1'b0;
`ifdef FIRE_CANNON_EN
    check("fire_valid", fire_valid, 1);
    check("fire_ready_low", fire_ready, 0);
    @(negedge clk);
    check("fire_pulse_1cyc", fire_valid, 0);
    fire_click = 1'b1;
    @(negedge clk);
    fire_click = 1'b0;
    check("fire_ignored", fire_valid, 0);
    ticks(119);
    check("fire_cd_119", fire_ready, 0);
    ticks(1);
    check("fire_cd_120", fire_ready, 1);
`else
    check("fire_off_valid", fire_valid, 0);
    check("fire_off_ready", fire_ready, 0);
`endif

    // Reset during EVAL discards the request
    @(negedge clk);
    click_valid = 1'b1; click_slot = 3'd0;
    @(negedge clk);
    click_valid = 1'b0;
    check("midrst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async", {busy, 14'(money)}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_pulse", {spawn_valid, reject, busy}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cat_deploy_ctrl.md
CAT_DEPLOY_CTRL -- requirements
Module: cat_deploy_ctrl

Interface
REQ-001 SHALL have parameter MONEY_MAX, default 14'd9999, saturation ceiling of money.
REQ-002 SHALL have parameter INCOME_BASE, default 14'd2, money added per tick at purse level 0.
REQ-003 SHALL have parameter FIRE_CD, default 8'd120, fire cooldown reload in ticks.
REQ-004 SHALL have clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have tick  input  1  one-cycle game timestep pulse.
REQ-007 SHALL have click_valid  input  1  card-frame click, one-cycle pulse.
REQ-008 SHALL have click_slot  input  3  frame index 0..7 (joker, fish, trap, jay, bomb, CY, hacker, elephant).
REQ-009 SHALL have purse_click  input  1  purse-button pulse.
REQ-010 SHALL have fire_click  input  1  fire-button pulse.
REQ-011 SHALL have money  output  14  current money.
REQ-012 SHALL have purse_level  output  3  purse level 0..7.
REQ-013 SHALL have slot_ready  output  8  bit i = slot i cooldown zero and money >= cost[i].
REQ-014 SHALL have spawn_valid  output  1  one-cycle deploy grant.
REQ-015 SHALL have spawn_type  output  3  slot granted, valid with spawn_valid.
REQ-016 SHALL have reject  output  1  one-cycle pulse, request denied.
REQ-017 SHALL have busy  output  1  high when FSM not IDLE.
REQ-018 SHALL have fire_ready, fire_valid  output  1 each  fire cooldown zero; one-cycle fire grant.

Function
REQ-019 SHALL use fixed cost[0..7] = 50,100,150,200,300,400,500,750 and cooldown reload cd[0..7] = 10,15,20,25,30,40,50,60 ticks.
REQ-020 SHALL run FSM IDLE->EVAL->ISSUE->IDLE, one cycle each; only IDLE accepts requests.
REQ-021 SHALL latch click_slot in IDLE when click_valid=1 (request type CARD); else latch purse request when purse_click=1; click_valid wins, simultaneous purse_click dropped.
REQ-022 SHALL drop, without reject, any click_valid/purse_click arriving while busy=1.
REQ-023 SHALL evaluate in EVAL: CARD grant iff cooldown[slot]==0 and money>=cost[slot]; purse grant iff level<7 and money>=50*(level+1).
REQ-024 SHALL, for a request latched at edge N, assert spawn_valid or reject at cycle N+2 (ISSUE), with money/cooldown/level updates visible the same cycle.
REQ-025 SHALL on CARD grant subtract cost, load cooldown[slot]=cd[slot]; on purse grant subtract 50*(level+1) and increment purse_level; purse grant raises neither spawn_valid nor reject.
REQ-026 SHALL on tick add INCOME_BASE*(purse_level+1), saturating at MONEY_MAX; same-cycle deduction: money_next = min(money - cost + income, MAX), never negative.
REQ-027 SHALL on tick decrement every nonzero cooldown, saturating at 0; a slot loaded in the same cycle takes the reload value, no decrement.
REQ-028 SHALL compute slot_ready, fire_ready combinationally from registered state.

Reset
REQ-029 SHALL on rst_n=0 immediately clear: money=0, purse_level=0, all cooldowns=0, fire cooldown=0, FSM=IDLE, spawn_valid/spawn_type/reject/fire_valid=0.
REQ-030 SHALL discard an in-flight request on reset mid-EVAL/ISSUE; no pulse after release.

Configuration
REQ-031 SHALL, with FIRE_CANNON_EN defined, on fire_click while fire_ready=1 pulse fire_valid next cycle and load fire cooldown FIRE_CD (tick rule per REQ-027), independent of FSM; fire_click with fire_ready=0 ignored.
REQ-032 SHALL, without FIRE_CANNON_EN, tie fire_ready=0, fire_valid=0, ignore fire_click, instantiate no fire counter.

Verification
REQ-033 SHALL test: reset, 25 ticks -> money=50; click slot 0 -> spawn_valid, spawn_type=0 at N+2, money=0, slot_ready[0]=0 for 10 ticks.
REQ-034 SHALL test: money=90, click slot 1 -> reject at N+2, money unchanged 90.
REQ-035 SHALL test: money=100, purse_click -> level 1, money=50, next tick +4.
REQ-036 SHALL test: click_valid and purse_click same cycle -> only card evaluated; second click at N+1 dropped, no reject.
REQ-037 SHALL test: tick coincident with ISSUE grant slot 0 at money=60 -> money=12; cooldown[0]=10, not 9.
REQ-038 SHALL test: money at MONEY_MAX, tick -> stays 9999; with FIRE_CANNON_EN, fire_click -> fire_valid next cycle, fire_ready low 120 ticks.
